// File: rtl/mips_instr_encoder_if.sv
// ---------------------------------------------------------------------------
// mips_instr_encoder_if
//   Bundle between an instruction-field source (loader / bench) and the
//   MIPS instruction encoder.
//
//   Source -> encoder : clear, in_valid, in_kind, in_rs, in_rt, in_rd,
//                       in_shamt, in_funct, in_imm
//   Encoder -> source : in_ready, imem_we, imem_addr, imem_wdata, count,
//                       full, err, err_flag
//
//   master : the field source (drives the bundle, observes status/imem port)
//   slave  : the encoder
// ---------------------------------------------------------------------------
interface mips_instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_kind;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;
  logic              err_flag;

  modport master (
    output clear, in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm,
    input  in_ready, imem_we, imem_addr, imem_wdata, count, full, err, err_flag
  );

  modport slave (
    input  clear, in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm,
    output in_ready, imem_we, imem_addr, imem_wdata, count, full, err, err_flag
  );
endinterface

// File: rtl/mips_instr_encoder.sv
// ---------------------------------------------------------------------------
// mips_instr_encoder
//   Assembles 32-bit MIPS instruction words from separate fields and writes
//   them to consecutive instruction-memory word addresses starting at 0.
//
//   Ports
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     bus    : mips_instr_encoder_if.slave
//                clear            sync clear of addr/count/full/err_flag
//                in_valid/ready   field-bundle handshake (ready is comb)
//                in_kind          0 RTYPE,1 ADDI,2 LW,3 SW,4 LH,5 LHU,
//                                 6 ANDI,7 ORI,8 BEQ, 9-15 illegal
//                in_rs..in_imm    instruction fields
//                imem_we/addr/wdata  one-cycle write to program memory
//                count            words written since reset/clear
//                full             count has reached DEPTH
//                err / err_flag   illegal-bundle pulse / sticky copy
//
//   Parameters
//     ADDR_W : imem word-address width
//     DEPTH  : program-region size in words (1 .. 2**ADDR_W)
// ---------------------------------------------------------------------------
module mips_instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mips_instr_encoder_if.slave  bus
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] C_ONE   = (ADDR_W + 1)'(1);

  // Legal R-type function codes: sll, add, sub, and, or, slt.
  localparam int              C_N_FUNCT   = 6;
  localparam logic [35:0]     C_LEGAL_FUNCT = {6'h00, 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  // Registered state and outputs
  state_t            r_state;
  logic              r_imem_we;
  logic [ADDR_W-1:0] r_imem_addr;
  logic [31:0]       r_imem_wdata;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_err;
  logic              r_err_flag;

  // Next-state values
  state_t            w_state_next;
  logic              w_imem_we_next;
  logic [ADDR_W-1:0] w_imem_addr_next;
  logic [31:0]       w_imem_wdata_next;
  logic [ADDR_W:0]   w_count_next;
  logic              w_full_next;
  logic              w_err_next;
  logic              w_err_flag_next;

  // Decode / encode
  logic [C_N_FUNCT-1:0] w_funct_hit;
  logic                 w_funct_ok;
  logic [5:0]           w_opcode;
  logic                 w_kind_itype;
  logic                 w_legal;
  logic [31:0]          w_word;
  logic                 w_ready;
  logic                 w_handshake;

  // -------------------------------------------------------------------------
  // R-type funct legality: compare against each entry of the legal table.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < C_N_FUNCT; gi++) begin : g_funct
      assign w_funct_hit[gi] = (bus.in_funct == C_LEGAL_FUNCT[gi*6 +: 6]);
    end
  endgenerate

  assign w_funct_ok = |w_funct_hit;

  // I-type opcode lookup; w_kind_itype is low for RTYPE and for kinds 9-15.
  always_comb begin
    w_opcode     = 6'h00;
    w_kind_itype = 1'b1;
    case (bus.in_kind)
      4'd1:    w_opcode = 6'h08;  // ADDI
      4'd2:    w_opcode = 6'h23;  // LW
      4'd3:    w_opcode = 6'h2B;  // SW
      4'd4:    w_opcode = 6'h21;  // LH
      4'd5:    w_opcode = 6'h25;  // LHU
      4'd6:    w_opcode = 6'h0C;  // ANDI
      4'd7:    w_opcode = 6'h0D;  // ORI
      4'd8:    w_opcode = 6'h04;  // BEQ
      default: w_kind_itype = 1'b0;
    endcase
  end

  assign w_legal = w_kind_itype | ((bus.in_kind == 4'd0) & w_funct_ok);

  // R-type ignores imm; I-type ignores rd/shamt/funct.
  assign w_word = (bus.in_kind == 4'd0)
                ? {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_funct}
                : {w_opcode, bus.in_rs, bus.in_rt, bus.in_imm};

  // -------------------------------------------------------------------------
  // Handshake. clear blocks acceptance so a same-cycle clear and bundle never
  // both take effect.
  // -------------------------------------------------------------------------
  assign w_ready     = (r_state == S_IDLE) & ~r_full & ~bus.clear;
  assign w_handshake = bus.in_valid & w_ready;

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next      = r_state;
    w_imem_we_next    = 1'b0;
    w_imem_addr_next  = r_imem_addr;
    w_imem_wdata_next = r_imem_wdata;
    w_count_next      = r_count;
    w_err_next        = 1'b0;
    w_err_flag_next   = r_err_flag;

    case (r_state)
      S_IDLE: begin
        if (bus.clear) begin
          w_count_next    = '0;
          w_err_flag_next = 1'b0;
        end else if (w_handshake) begin
          if (w_legal) begin
            w_imem_we_next    = 1'b1;
            w_imem_addr_next  = r_count[ADDR_W-1:0];
            w_imem_wdata_next = w_word;
            w_state_next      = S_WRITE;
          end else begin
            // Illegal bundle is consumed: flag it, write nothing.
            w_err_next      = 1'b1;
            w_err_flag_next = 1'b1;
          end
        end
      end

      S_WRITE: begin
        // The strobe issued on entry completes here; a clear arriving now
        // wins over the increment.
        w_state_next = S_IDLE;
        if (bus.clear) begin
          w_count_next    = '0;
          w_err_flag_next = 1'b0;
        end else begin
          w_count_next = r_count + C_ONE;
        end
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  // full tracks the count it will sit beside, so both update on one edge.
  assign w_full_next = (w_count_next == C_DEPTH);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_err        <= 1'b0;
      r_err_flag   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_imem_we    <= w_imem_we_next;
      r_imem_addr  <= w_imem_addr_next;
      r_imem_wdata <= w_imem_wdata_next;
      r_count      <= w_count_next;
      r_full       <= w_full_next;
      r_err        <= w_err_next;
      r_err_flag   <= w_err_flag_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.in_ready   = w_ready;
  assign bus.imem_we    = r_imem_we;
  assign bus.imem_addr  = r_imem_addr;
  assign bus.imem_wdata = r_imem_wdata;
  assign bus.count      = r_count;
  assign bus.full       = r_full;
  assign bus.err        = r_err;
  assign bus.err_flag   = r_err_flag;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_mips_instr_encoder
//   Directed bench for mips_instr_encoder with a four-word program region.
// ---------------------------------------------------------------------------
module tb_mips_instr_encoder;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mips_instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  mips_instr_encoder #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
    $display("check %-14s observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic drive(input logic [3:0] kind, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] shamt, input logic [5:0] funct,
                       input logic [15:0] imm);
    bus.in_valid = 1'b1;
    bus.in_kind  = kind;
    bus.in_rs    = rs;
    bus.in_rt    = rt;
    bus.in_rd    = rd;
    bus.in_shamt = shamt;
    bus.in_funct = funct;
    bus.in_imm   = imm;
  endtask

  // Present one legal bundle, then check the write cycle and the count update.
  task automatic write_one(input string tag, input logic [3:0] kind, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] shamt,
                           input logic [5:0] funct, input logic [15:0] imm,
                           input logic [31:0] exp_word, input logic [31:0] exp_addr,
                           input logic [31:0] exp_count_after);
    drive(kind, rs, rt, rd, shamt, funct, imm);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, "_we"},    32'(bus.imem_we),    32'd1);
    chk({tag, "_addr"},  32'(bus.imem_addr),  exp_addr);
    chk({tag, "_wdata"}, bus.imem_wdata,      exp_word);
    chk({tag, "_rdy"},   32'(bus.in_ready),   32'd0);
    @(negedge clk);
    chk({tag, "_we0"},   32'(bus.imem_we),    32'd0);
    chk({tag, "_cnt"},   32'(bus.count),      exp_count_after);
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_kind  = '0;
    bus.in_rs    = '0;
    bus.in_rt    = '0;
    bus.in_rd    = '0;
    bus.in_shamt = '0;
    bus.in_funct = '0;
    bus.in_imm   = '0;

    // ---- reset state ----
    #2;
    chk("rst_we",    32'(bus.imem_we),    32'd0);
    chk("rst_addr",  32'(bus.imem_addr),  32'd0);
    chk("rst_wdata", bus.imem_wdata,      32'd0);
    chk("rst_count", 32'(bus.count),      32'd0);
    chk("rst_full",  32'(bus.full),       32'd0);
    chk("rst_err",   32'(bus.err),        32'd0);
    chk("rst_errf",  32'(bus.err_flag),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rdy_idle",  32'(bus.in_ready),   32'd1);
    @(negedge clk);

    // ---- T1: ADDI ----
    write_one("t1_addi", 4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0005,
              32'h2022_0005, 32'd0, 32'd1);
    chk("t1_addr_hold",  32'(bus.imem_addr), 32'd0);
    chk("t1_wdata_hold", bus.imem_wdata,     32'h2022_0005);

    // clear so the next program starts at 0
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    chk("t1_clr_cnt", 32'(bus.count), 32'd0);

    // ---- T2: RTYPE add, BEQ, RTYPE sll ----
    write_one("t2_add", 4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hBEEF,
              32'h0022_1820, 32'd0, 32'd1);
    write_one("t2_beq", 4'd8, 5'd3, 5'd0, 5'd7, 5'd9, 6'h3F, 16'hFFFF,
              32'h1060_FFFF, 32'd1, 32'd2);
    write_one("t2_sll", 4'd0, 5'd0, 5'd2, 5'd4, 5'd3, 6'h00, 16'h0000,
              32'h0002_20C0, 32'd2, 32'd3);

    // ---- T3: illegal bundles ----
    drive(4'd12, 5'd1, 5'd1, 5'd1, 5'd0, 6'h20, 16'h1234);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("t3_k12_err",  32'(bus.err),      32'd1);
    chk("t3_k12_we",   32'(bus.imem_we),  32'd0);
    chk("t3_k12_errf", 32'(bus.err_flag), 32'd1);
    chk("t3_k12_rdy",  32'(bus.in_ready), 32'd1);
    @(negedge clk);
    chk("t3_err_pulse", 32'(bus.err),     32'd0);
    chk("t3_errf_hold", 32'(bus.err_flag), 32'd1);
    chk("t3_cnt_a",     32'(bus.count),   32'd3);

    drive(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h08, 16'h0000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("t3_jr_err",  32'(bus.err),     32'd1);
    chk("t3_jr_we",   32'(bus.imem_we), 32'd0);
    @(negedge clk);
    chk("t3_cnt_b",   32'(bus.count),   32'd3);
    chk("t3_wd_hold", bus.imem_wdata,   32'h0002_20C0);

    // clear together with a valid bundle: no handshake
    bus.clear = 1'b1;
    drive(4'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0001);
    #1;
    chk("t3_clr_rdy", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    chk("t3_clr_we",   32'(bus.imem_we),  32'd0);
    chk("t3_clr_errf", 32'(bus.err_flag), 32'd0);
    chk("t3_clr_cnt",  32'(bus.count),    32'd0);
    @(negedge clk);
    chk("t3_clr_we2",  32'(bus.imem_we),  32'd0);

    // ---- T4: fill the region with in_valid held high ----
    drive(4'd2, 5'd0, 5'd1, 5'd0, 5'd0, 6'h00, 16'h0000);   // LW
    @(negedge clk);
    chk("t4_lw_we",    32'(bus.imem_we),  32'd1);
    chk("t4_lw_addr",  32'(bus.imem_addr), 32'd0);
    chk("t4_lw_wdata", bus.imem_wdata,    32'h8C01_0000);
    drive(4'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00, 16'h0004);   // SW
    @(negedge clk);
    chk("t4_cnt1",     32'(bus.count),    32'd1);
    chk("t4_gap1",     32'(bus.imem_we),  32'd0);
    @(negedge clk);
    chk("t4_sw_addr",  32'(bus.imem_addr), 32'd1);
    chk("t4_sw_wdata", bus.imem_wdata,    32'hAC22_0004);
    drive(4'd4, 5'd2, 5'd3, 5'd0, 5'd0, 6'h00, 16'h0008);   // LH
    @(negedge clk);
    chk("t4_cnt2",     32'(bus.count),    32'd2);
    @(negedge clk);
    chk("t4_lh_addr",  32'(bus.imem_addr), 32'd2);
    chk("t4_lh_wdata", bus.imem_wdata,    32'h8443_0008);
    drive(4'd5, 5'd3, 5'd4, 5'd0, 5'd0, 6'h00, 16'h000C);   // LHU
    @(negedge clk);
    chk("t4_cnt3",     32'(bus.count),    32'd3);
    chk("t4_full0",    32'(bus.full),     32'd0);
    @(negedge clk);
    chk("t4_lhu_we",   32'(bus.imem_we),  32'd1);
    chk("t4_lhu_addr", 32'(bus.imem_addr), 32'd3);
    chk("t4_lhu_wd",   bus.imem_wdata,    32'h9464_000C);
    drive(4'd2, 5'd0, 5'd1, 5'd0, 5'd0, 6'h00, 16'h0000);   // LW again, still valid
    @(negedge clk);
    chk("t4_cnt4",     32'(bus.count),    32'd4);
    chk("t4_full",     32'(bus.full),     32'd1);
    chk("t4_rdy_full", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("t4_stall_we", 32'(bus.imem_we),  32'd0);
    chk("t4_stall_cnt", 32'(bus.count),   32'd4);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    chk("t4_clr_cnt",  32'(bus.count),    32'd0);
    chk("t4_clr_full", 32'(bus.full),     32'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("t4_re_we",    32'(bus.imem_we),  32'd1);
    chk("t4_re_addr",  32'(bus.imem_addr), 32'd0);
    chk("t4_re_wdata", bus.imem_wdata,    32'h8C01_0000);
    @(negedge clk);
    chk("t4_re_cnt",   32'(bus.count),    32'd1);

    // ---- T5: reset during WRITE ----
    drive(4'd6, 5'd5, 5'd6, 5'd0, 5'd0, 6'h00, 16'h00FF);   // ANDI
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("t5_andi_we",  32'(bus.imem_we),  32'd1);
    chk("t5_andi_wd",  bus.imem_wdata,    32'h30A6_00FF);
    chk("t5_andi_ad",  32'(bus.imem_addr), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_we",   32'(bus.imem_we),  32'd0);
    chk("t5_rst_cnt",  32'(bus.count),    32'd0);
    chk("t5_rst_wd",   bus.imem_wdata,    32'd0);
    @(negedge clk);
    chk("t5_rst_cnt2", 32'(bus.count),    32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    write_one("t5_ori", 4'd7, 5'd7, 5'd8, 5'd0, 5'd0, 6'h00, 16'h1234,
              32'h34E8_1234, 32'd0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
